// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, PC step, reset PC and fetch FSM encoding.
package cpu_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          INSTR_W_DEF  = 32;
    localparam int          PC_STEP      = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO with push/pop/flush; head is read straight from storage.
module fetch_queue #(
    parameter  int DEPTH = 4,
    parameter  int W     = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     push_data,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // When full with a pop, the write lands in the slot being vacated.
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: PC sequencing, prefetch queue toward decode, redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter  int          ADDR_W      = ADDR_W_DEF,
    parameter  int          INSTR_W     = INSTR_W_DEF,
    parameter  int          QUEUE_DEPTH = 4,
    parameter  logic [31:0] RESET_PC    = RESET_PC_DEF,
    localparam int          CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [CNT_W-1:0]   queue_count,
    output logic               fault,
    output logic [1:0]         dbg_state
);

    // Handshake: a head entry transfers on any rising edge where out_valid && out_ready;
    // the head stays stable while out_valid is high and out_ready is low.

    fetch_state_e       state_q, state_d, state_by_en;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               push, pop, full;
    logic [ADDR_W+INSTR_W-1:0] head_data;

    assign full = (queue_count == CNT_W'(QUEUE_DEPTH));
    assign pop  = out_valid && out_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
`endif

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        push        = 1'b0;
        state_by_en = fetch_en ? ST_FETCH : ST_IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d     = fault_q;
`endif
        if (state_q != ST_FAULT) begin
            state_d = state_by_en;
        end
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end else begin
                fetch_pc_d = redirect_pc;
                fault_d    = 1'b0;
                state_d    = state_by_en;
            end
`else
            fetch_pc_d = redirect_pc & ~ADDR_W'(3);
`endif
        end else if (state_q == ST_FETCH && fetch_en && (!full || pop)) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC[ADDR_W-1:0];
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .W     (ADDR_W + INSTR_W)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data ({fetch_pc_q, imem_instr}),
        .head_data (head_data),
        .count     (queue_count)
    );

    assign imem_addr = fetch_pc_q;
    assign out_valid = (queue_count != '0);
    assign out_pc    = head_data[ADDR_W+INSTR_W-1:INSTR_W];
    assign out_instr = head_data[INSTR_W-1:0];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  queue_count;
    logic        fault;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .queue_count    (queue_count),
        .fault          (fault),
        .dbg_state      (dbg_state)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_count"}, 32'(queue_count), 32'd0);
        chk({tag, "_pc"}, out_pc, 32'd0);
        chk({tag, "_instr"}, out_instr, 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        // Reset state
        step();
        chk_reset_state("rst0");

        // Streaming with out_ready high: one instruction per cycle
        reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        step();
        chk("go_state", 32'(dbg_state), 32'(ST_FETCH));
        chk("go_valid", 32'(out_valid), 32'd0);
        step();
        chk("s0_pc", out_pc, 32'd0);
        chk("s0_instr", out_instr, mem_word(32'd0));
        chk("s0_addr", imem_addr, 32'd4);
        chk("s0_count", 32'(queue_count), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("stream_pc", out_pc, 32'(4 * k));
            chk("stream_instr", out_instr, mem_word(32'(4 * k)));
        end
        chk("stream_count", 32'(queue_count), 32'd1);

        // Stall for 6 cycles fills the queue and holds the PC
        reset = 1'b1; out_ready = 1'b0;
        step();
        chk_reset_state("rst1");
        reset = 1'b0;
        repeat (6) step();
        chk("full_count", 32'(queue_count), 32'd4);
        chk("full_addr", imem_addr, 32'd16);
        chk("full_head", out_pc, 32'd0);
        chk("full_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("drain_pc", out_pc, 32'(4 * k));
            chk("drain_count", 32'(queue_count), 32'd4);
        end

        // Redirect with a same-cycle pop: 8 consumed, 12 discarded
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        chk("pre_redir_pc", out_pc, 32'd8);
        out_ready = 1'b0;
        step();
        chk("pre_redir_count", 32'(queue_count), 32'd2);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd64;
        step();
        redirect_valid = 1'b0;
        chk("redir_count", 32'(queue_count), 32'd0);
        chk("redir_addr", imem_addr, 32'd64);
        step();
        chk("redir_valid", 32'(out_valid), 32'd1);
        chk("redir_pc", out_pc, 32'd64);
        chk("redir_instr", out_instr, mem_word(32'd64));

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        step();
        chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
        step();
        chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc2", out_pc, 32'h0000_0000);
        chk("wrap_instr", out_instr, mem_word(32'd0));
        chk("wrap_addr", imem_addr, 32'd4);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_state", 32'(dbg_state), 32'(ST_FAULT));
        chk("mis_count", 32'(queue_count), 32'd0);
        chk("mis_addr", imem_addr, 32'd4);
        repeat (2) step();
        chk("mis_hold_count", 32'(queue_count), 32'd0);
        chk("mis_hold_addr", imem_addr, 32'd4);
        chk("mis_hold_fault", 32'(fault), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        chk("rec_fault", 32'(fault), 32'd0);
        chk("rec_addr", imem_addr, 32'h20);
        chk("rec_state", 32'(dbg_state), 32'(ST_FETCH));
`else
        chk("mis_fault", 32'(fault), 32'd0);
        chk("mis_addr", imem_addr, 32'h20);
        chk("mis_count", 32'(queue_count), 32'd0);
`endif
        step();
        chk("mis_pc", out_pc, 32'h20);
        chk("mis_instr", out_instr, mem_word(32'h20));

        // Reset while the queue is full
        out_ready = 1'b0;
        repeat (4) step();
        chk("pre_rst_count", 32'(queue_count), 32'd4);
        reset = 1'b1;
        step();
        chk_reset_state("rst2");
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
